// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end that shares one serial divider among
// NUM_REQ requesters. A granted request is captured into holding registers,
// issued to the divider one cycle later, and the result is routed back only
// to the requester that owns the in-flight operation.
module div_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned ID_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_vld_i,
    output logic [NUM_REQ-1:0]         req_rdy_o,
    input  logic [NUM_REQ*ID_BITS-1:0] req_id_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_op_a_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_op_b_i,
    input  logic [NUM_REQ*2-1:0]       req_opcode_i,
    input  logic [NUM_REQ-1:0]         req_flush_i,
    output logic [NUM_REQ-1:0]         rsp_vld_o,
    input  logic [NUM_REQ-1:0]         rsp_rdy_i,
    output logic [ID_BITS-1:0]         rsp_id_o,
    output logic [WIDTH-1:0]           rsp_res_o,
    output logic                       div_in_vld_o,
    output logic                       div_flush_o,
    output logic                       div_out_rdy_o,
    input  logic                       div_in_rdy_i,
    input  logic                       div_out_vld_i,
    output logic [ID_BITS-1:0]         div_id_o,
    output logic [WIDTH-1:0]           div_op_a_o,
    output logic [WIDTH-1:0]           div_op_b_o,
    output logic [1:0]                 div_opcode_o,
    input  logic [ID_BITS-1:0]         div_id_i,
    input  logic [WIDTH-1:0]           div_res_i
);

    localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    logic [1:0]         r_state;
    logic [OW-1:0]      r_owner;
    logic [OW-1:0]      r_ptr;
    logic [ID_BITS-1:0] r_id;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [1:0]         r_opcode;

    logic [1:0]    w_state_d;
    logic          w_gnt_vld;
    logic [OW-1:0] w_gnt_idx;
    logic [OW-1:0] w_cand;
    logic          w_accept;
    logic          w_own_flush;
    logic          w_rsp_hs;
    logic          w_release;
    logic [OW-1:0] w_next_ptr;

    // (base + off) mod NUM_REQ; off is always below NUM_REQ
    function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] base,
                                               input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return OW'(s);
    endfunction

    // Round-robin search from r_ptr upward; flushed requesters are skipped
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_cand = wrap_add(r_ptr, k);
            if (!w_gnt_vld && req_vld_i[w_cand] && !req_flush_i[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    // Control decode: accept, owner flush, result handshake, pointer advance
    always_comb begin
        w_accept    = (r_state == ST_IDLE) && div_in_rdy_i && w_gnt_vld;
        w_own_flush = ((r_state == ST_ISSUE) || (r_state == ST_BUSY)) && req_flush_i[r_owner];
        w_rsp_hs    = (r_state == ST_BUSY) && !w_own_flush && div_out_vld_i
                      && rsp_rdy_i[r_owner];
        w_next_ptr  = (r_owner == OW'(NUM_REQ - 1)) ? '0 : r_owner + OW'(1);
    end

    // Next-state logic; w_release marks the end of an owner's tenure
    always_comb begin
        w_state_d = r_state;
        w_release = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_own_flush) begin
                    w_state_d = ST_IDLE;
                    w_release = 1'b1;
                end else begin
                    w_state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_own_flush || w_rsp_hs) begin
                    w_state_d = ST_IDLE;
                    w_release = 1'b1;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Requester-facing outputs; the response path is combinational from the divider
    always_comb begin
        req_rdy_o     = '0;
        rsp_vld_o     = '0;
        rsp_res_o     = '0;
        rsp_id_o      = '0;
        div_out_rdy_o = 1'b0;
        if (w_accept) begin
            req_rdy_o[w_gnt_idx] = 1'b1;
        end
        if (r_state == ST_BUSY) begin
            rsp_res_o = div_res_i;
            rsp_id_o  = div_id_i;
            // An owner flush suppresses delivery even if a result is ready
            if (!w_own_flush) begin
                rsp_vld_o[r_owner] = div_out_vld_i;
                div_out_rdy_o      = rsp_rdy_i[r_owner];
            end
        end
    end

    // Divider-facing outputs
    always_comb begin
        div_in_vld_o = (r_state == ST_ISSUE) && !w_own_flush;
        div_flush_o  = w_own_flush;
        div_id_o     = r_id;
        div_op_a_o   = r_op_a;
        div_op_b_o   = r_op_b;
        div_opcode_o = r_opcode;
    end

    // State, ownership, pointer and holding registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_ptr    <= '0;
            r_id     <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_opcode <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_release) begin
                r_ptr <= w_next_ptr;
            end
            if (w_accept) begin
                r_owner  <= w_gnt_idx;
                r_id     <= req_id_i[w_gnt_idx*ID_BITS +: ID_BITS];
                r_op_a   <= req_op_a_i[w_gnt_idx*WIDTH +: WIDTH];
                r_op_b   <= req_op_b_i[w_gnt_idx*WIDTH +: WIDTH];
                r_opcode <= req_opcode_i[w_gnt_idx*2 +: 2];
            end
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed tests for div_arbiter with a behavioural serial
// divider (fixed latency, holds result until taken, cleared by flush/reset).
module tb_div_arbiter;

    localparam int N   = 2;
    localparam int W   = 64;
    localparam int IB  = 3;
    localparam int LAT = 4;

    logic            clk;
    logic            rst_ni;
    logic [N-1:0]    req_vld;
    logic [N-1:0]    req_rdy_o;
    logic [N*IB-1:0] req_id;
    logic [N*W-1:0]  req_op_a;
    logic [N*W-1:0]  req_op_b;
    logic [N*2-1:0]  req_opcode;
    logic [N-1:0]    req_flush;
    logic [N-1:0]    rsp_vld_o;
    logic [N-1:0]    rsp_rdy;
    logic [IB-1:0]   rsp_id_o;
    logic [W-1:0]    rsp_res_o;
    logic            div_in_vld_o;
    logic            div_flush_o;
    logic            div_out_rdy_o;
    logic            div_in_rdy;
    logic            div_out_vld;
    logic [IB-1:0]   div_id_o;
    logic [W-1:0]    div_op_a_o;
    logic [W-1:0]    div_op_b_o;
    logic [1:0]      div_opcode_o;
    logic [IB-1:0]   div_id;
    logic [W-1:0]    div_res;

    int n_vec = 0;
    int n_err = 0;

    div_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_BITS(IB)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req_vld_i     (req_vld),
        .req_rdy_o     (req_rdy_o),
        .req_id_i      (req_id),
        .req_op_a_i    (req_op_a),
        .req_op_b_i    (req_op_b),
        .req_opcode_i  (req_opcode),
        .req_flush_i   (req_flush),
        .rsp_vld_o     (rsp_vld_o),
        .rsp_rdy_i     (rsp_rdy),
        .rsp_id_o      (rsp_id_o),
        .rsp_res_o     (rsp_res_o),
        .div_in_vld_o  (div_in_vld_o),
        .div_flush_o   (div_flush_o),
        .div_out_rdy_o (div_out_rdy_o),
        .div_in_rdy_i  (div_in_rdy),
        .div_out_vld_i (div_out_vld),
        .div_id_o      (div_id_o),
        .div_op_a_o    (div_op_a_o),
        .div_op_b_o    (div_op_b_o),
        .div_opcode_o  (div_opcode_o),
        .div_id_i      (div_id),
        .div_res_i     (div_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, got no finish, want finish");
        $fatal(1);
    end

    function automatic logic [W-1:0] calc(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        case (op)
            2'd0:    return a / b;
            2'd1:    return $signed(a) / $signed(b);
            2'd2:    return a % b;
            default: return $signed(a) % $signed(b);
        endcase
    endfunction

    // Divider model: sample at negedge, update just after the following posedge
    logic          m_busy, m_s_in, m_s_flush, m_s_out, m_s_rst;
    int            m_cnt;
    logic [W-1:0]  m_a, m_b;
    logic [1:0]    m_op;
    logic [IB-1:0] m_id;
    initial begin
        m_busy = 1'b0; m_cnt = 0;
        div_in_rdy = 1'b1; div_out_vld = 1'b0; div_res = '0; div_id = '0;
        forever begin
            @(negedge clk);
            m_s_in    = div_in_vld_o && div_in_rdy;
            m_s_flush = div_flush_o;
            m_s_out   = div_out_vld && div_out_rdy_o;
            m_s_rst   = !rst_ni;
            m_a = div_op_a_o; m_b = div_op_b_o; m_op = div_opcode_o; m_id = div_id_o;
            @(posedge clk);
            #1;
            if (m_s_rst || m_s_flush || m_s_out) begin
                m_busy = 1'b0; div_out_vld = 1'b0;
            end else if (m_s_in) begin
                m_busy = 1'b1; m_cnt = LAT;
                div_res = calc(m_op, m_a, m_b); div_id = m_id;
            end else if (m_busy && !div_out_vld) begin
                if (m_cnt == 0) div_out_vld = 1'b1;
                else m_cnt = m_cnt - 1;
            end
            div_in_rdy = !m_busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [IB-1:0] id, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [1:0] op);
        req_id[i*IB +: IB]   = id;
        req_op_a[i*W +: W]   = a;
        req_op_b[i*W +: W]   = b;
        req_opcode[i*2 +: 2] = op;
    endtask

    // Steps cycles until a response bit shows at a negedge (bounded)
    task automatic wait_rsp(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_vld_o != '0) begin
                seen = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; req_vld = '0; req_flush = '0; rsp_rdy = '0;
        req_id = '0; req_op_a = '0; req_op_b = '0; req_opcode = '0;
        tick(); tick();
        @(negedge clk);
        n_vec++;
        if ({req_rdy_o, rsp_vld_o, div_in_vld_o, div_flush_o, div_out_rdy_o} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {req_rdy_o, rsp_vld_o, div_in_vld_o, div_flush_o, div_out_rdy_o});
        end
        n_vec++;
        if ({rsp_res_o, rsp_id_o, div_id_o, div_op_a_o, div_op_b_o, div_opcode_o} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0",
                     {rsp_res_o, rsp_id_o, div_id_o, div_op_a_o, div_op_b_o, div_opcode_o});
        end
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_single();
        bit seen;
        set_req(0, 3'd5, 64'd100, 64'd7, 2'd0);
        req_vld = 2'b01; rsp_rdy = 2'b11;
        @(negedge clk);
        n_vec++;
        if (req_rdy_o !== 2'b01) begin
            n_err++; $display("FAIL single_rdy: got %b want 01", req_rdy_o);
        end
        tick();
        req_vld = 2'b00;
        @(negedge clk);
        n_vec++;
        if ({div_in_vld_o, req_rdy_o, div_op_a_o, div_op_b_o, div_id_o, div_opcode_o} !==
            {1'b1, 2'b00, 64'd100, 64'd7, 3'd5, 2'd0}) begin
            n_err++;
            $display("FAIL single_issue: got vld=%b rdy=%b a=%0d b=%0d id=%0d op=%0d want 1 00 100 7 5 0",
                     div_in_vld_o, req_rdy_o, div_op_a_o, div_op_b_o, div_id_o, div_opcode_o);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (div_in_vld_o !== 1'b0) begin
            n_err++; $display("FAIL single_vld_once: got %b want 0", div_in_vld_o);
        end
        tick();
        wait_rsp(seen);
        n_vec++;
        if (!seen || rsp_vld_o !== 2'b01 || rsp_res_o !== 64'd14 || rsp_id_o !== 3'd5) begin
            n_err++;
            $display("FAIL single_rsp: got seen=%0d vld=%b res=%0d id=%0d want 1 01 14 5",
                     seen, rsp_vld_o, rsp_res_o, rsp_id_o);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (rsp_vld_o !== 2'b00) begin
            n_err++; $display("FAIL single_done: got %b want 00", rsp_vld_o);
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        logic [N-1:0]  exp_rdy;
        logic [W-1:0]  exp_res;
        logic [IB-1:0] exp_id;
        tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        set_req(0, 3'd1, 64'd100, 64'd7, 2'd0);
        set_req(1, 3'd2, -64'sd7, 64'd2, 2'd3);
        req_vld = 2'b11; rsp_rdy = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp_rdy = (g % 2 == 0) ? 2'b01 : 2'b10;
            exp_res = (g % 2 == 0) ? 64'd14 : 64'hFFFF_FFFF_FFFF_FFFF;
            exp_id  = (g % 2 == 0) ? 3'd1 : 3'd2;
            @(negedge clk);
            n_vec++;
            if (req_rdy_o !== exp_rdy) begin
                n_err++; $display("FAIL b2b_grant%0d: got %b want %b", g, req_rdy_o, exp_rdy);
            end
            tick();
            @(negedge clk);
            n_vec++;
            if (req_rdy_o !== 2'b00 || div_in_vld_o !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_wait%0d: got rdy=%b vld=%b want 00 1", g, req_rdy_o, div_in_vld_o);
            end
            tick();
            wait_rsp(seen);
            n_vec++;
            if (!seen || rsp_vld_o !== exp_rdy || rsp_res_o !== exp_res || rsp_id_o !== exp_id) begin
                n_err++;
                $display("FAIL b2b_rsp%0d: got vld=%b res=%h id=%0d want %b %h %0d",
                         g, rsp_vld_o, rsp_res_o, rsp_id_o, exp_rdy, exp_res, exp_id);
            end
            tick();
        end
        req_vld = 2'b00;
    endtask

    task automatic test_owner_flush();
        bit seen;
        req_vld = 2'b10;
        @(negedge clk);
        n_vec++;
        if (req_rdy_o !== 2'b10) begin
            n_err++; $display("FAIL oflush_grant: got %b want 10", req_rdy_o);
        end
        tick();
        req_vld = 2'b00;
        tick(); tick(); tick();
        req_flush = 2'b10;
        @(negedge clk);
        n_vec++;
        if ({div_flush_o, rsp_vld_o, div_out_rdy_o, div_in_vld_o} !== 5'b1_00_0_0) begin
            n_err++;
            $display("FAIL oflush_pulse: got flush=%b vld=%b ordy=%b ivld=%b want 1 00 0 0",
                     div_flush_o, rsp_vld_o, div_out_rdy_o, div_in_vld_o);
        end
        tick();
        req_flush = 2'b00;
        req_vld = 2'b11;
        @(negedge clk);
        n_vec++;
        if (req_rdy_o !== 2'b01 || div_flush_o !== 1'b0 || rsp_vld_o !== 2'b00) begin
            n_err++;
            $display("FAIL oflush_next: got rdy=%b flush=%b vld=%b want 01 0 00",
                     req_rdy_o, div_flush_o, rsp_vld_o);
        end
        tick();
        req_vld = 2'b00;
        tick();
        wait_rsp(seen);
        n_vec++;
        if (!seen || rsp_vld_o !== 2'b01 || rsp_res_o !== 64'd14) begin
            n_err++;
            $display("FAIL oflush_after: got vld=%b res=%0d want 01 14", rsp_vld_o, rsp_res_o);
        end
        tick();
    endtask

    task automatic test_nonowner_flush();
        bit seen;
        set_req(0, 3'd3, -64'sd20, 64'd3, 2'd1);
        req_vld = 2'b11; req_flush = 2'b10;
        @(negedge clk);
        n_vec++;
        if (req_rdy_o !== 2'b01) begin
            n_err++; $display("FAIL nflush_skip: got %b want 01", req_rdy_o);
        end
        tick();
        req_vld = 2'b00;
        @(negedge clk);
        n_vec++;
        if (div_flush_o !== 1'b0 || div_in_vld_o !== 1'b1) begin
            n_err++;
            $display("FAIL nflush_issue: got flush=%b vld=%b want 0 1", div_flush_o, div_in_vld_o);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (div_flush_o !== 1'b0) begin
            n_err++; $display("FAIL nflush_busy: got %b want 0", div_flush_o);
        end
        tick();
        req_flush = 2'b00;
        wait_rsp(seen);
        n_vec++;
        if (!seen || rsp_vld_o !== 2'b01 || rsp_res_o !== 64'hFFFF_FFFF_FFFF_FFFA
            || rsp_id_o !== 3'd3) begin
            n_err++;
            $display("FAIL nflush_rsp: got vld=%b res=%h id=%0d want 01 fffffffffffffffa 3",
                     rsp_vld_o, rsp_res_o, rsp_id_o);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit seen;
        set_req(0, 3'd6, 64'd50, 64'd7, 2'd2);
        req_vld = 2'b01; rsp_rdy = 2'b00;
        tick();
        req_vld = 2'b00;
        tick();
        wait_rsp(seen);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                tick();
                @(negedge clk);
            end
            n_vec++;
            if (!seen || rsp_vld_o !== 2'b01 || rsp_res_o !== 64'd1 || div_out_rdy_o !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: got vld=%b res=%0d ordy=%b want 01 1 0",
                         i, rsp_vld_o, rsp_res_o, div_out_rdy_o);
            end
        end
        tick();
        rsp_rdy = 2'b01;
        @(negedge clk);
        n_vec++;
        if (rsp_vld_o !== 2'b01 || div_out_rdy_o !== 1'b1 || rsp_id_o !== 3'd6) begin
            n_err++;
            $display("FAIL bp_release: got vld=%b ordy=%b id=%0d want 01 1 6",
                     rsp_vld_o, div_out_rdy_o, rsp_id_o);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (rsp_vld_o !== 2'b00 || div_out_rdy_o !== 1'b0) begin
            n_err++;
            $display("FAIL bp_idle: got vld=%b ordy=%b want 00 0", rsp_vld_o, div_out_rdy_o);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        tick();
        set_req(0, 3'd7, 64'd9, 64'd3, 2'd0);
        req_vld = 2'b01; rsp_rdy = 2'b11;
        tick();
        req_vld = 2'b00;
        tick(); tick();
        rst_ni = 1'b0;
        tick();
        @(negedge clk);
        n_vec++;
        if ({req_rdy_o, rsp_vld_o, div_in_vld_o, div_flush_o, div_out_rdy_o} !== '0) begin
            n_err++;
            $display("FAIL rmid_ctrl: got %b want 0",
                     {req_rdy_o, rsp_vld_o, div_in_vld_o, div_flush_o, div_out_rdy_o});
        end
        n_vec++;
        if ({rsp_res_o, rsp_id_o, div_id_o, div_op_a_o, div_op_b_o, div_opcode_o} !== '0) begin
            n_err++;
            $display("FAIL rmid_data: got %h want 0",
                     {rsp_res_o, rsp_id_o, div_id_o, div_op_a_o, div_op_b_o, div_opcode_o});
        end
        tick();
        rst_ni = 1'b1;
        req_vld = 2'b11;
        @(negedge clk);
        n_vec++;
        if (req_rdy_o !== 2'b01) begin
            n_err++; $display("FAIL rmid_ptr: got %b want 01", req_rdy_o);
        end
        tick();
        req_vld = 2'b00;
        tick();
        wait_rsp(seen);
        n_vec++;
        if (!seen || rsp_vld_o !== 2'b01 || rsp_res_o !== 64'd3 || rsp_id_o !== 3'd7) begin
            n_err++;
            $display("FAIL rmid_rsp: got vld=%b res=%0d id=%0d want 01 3 7",
                     rsp_vld_o, rsp_res_o, rsp_id_o);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_owner_flush();
        test_nonowner_flush();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter and sequencer that shares one serial divider among `NUM_REQ` requesters, for example several issue ports or hart contexts. It accepts a request, holds the operands in registers and issues them to the divider one cycle later to respect the divider's rdy→vld delay. It records which requester owns the in-flight operation, routes the result back to that owner only, and turns an owner flush into a divider flush.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (≥2).
- `WIDTH`, 64: operand/result width.
- `ID_BITS`, 3: transaction-id width.

Ports (clock and reset first):
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_ni`  in  1  **reset, synchronous, active-low**.
- `req_vld_i`  in  NUM_REQ  per-requester request valid.
- `req_rdy_o`  out  NUM_REQ  per-requester accept; at most one bit high.
- `req_id_i`  in  NUM_REQ*ID_BITS  packed ids; slice i belongs to requester i.
- `req_op_a_i`, `req_op_b_i`  in  NUM_REQ*WIDTH  packed operands.
- `req_opcode_i`  in  NUM_REQ*2  packed opcodes: 0 udiv, 1 div, 2 urem, 3 rem.
- `req_flush_i`  in  NUM_REQ  per-requester kill.
- `rsp_vld_o`  out  NUM_REQ  result valid, owner bit only.
- `rsp_rdy_i`  in  NUM_REQ  per-requester result ready.
- `rsp_id_o`  out  ID_BITS  id of the result on the shared bus.
- `rsp_res_o`  out  WIDTH  shared result bus.
- `div_in_vld_o`, `div_flush_o`, `div_out_rdy_o`  out  1  divider control.
- `div_in_rdy_i`, `div_out_vld_i`  in  1  divider status.
- `div_id_o`  out  ID_BITS  issued id.
- `div_op_a_o`, `div_op_b_o`  out  WIDTH  issued operands.
- `div_opcode_o`  out  2  issued opcode.
- `div_id_i`  in  ID_BITS  divider result id.
- `div_res_i`  in  WIDTH  divider result.

## Operation
- **State:**
  - FSM states: IDLE, ISSUE, BUSY.
  - Registers: `owner_q` (clog2 NUM_REQ bits), round-robin pointer `ptr_q`, and holding registers for id, op_a, op_b and opcode.
- **Arbitration:**
  - The grant goes to the first i with `req_vld_i[i]` & ~`req_flush_i[i]`, searching from `ptr_q` upward with wrap modulo NUM_REQ.
  - Grant is purely combinational from the current inputs and `ptr_q`.
- **IDLE:**
  - Acceptance requires `div_in_rdy_i`=1 and a grant to index g.
  - On acceptance: `req_rdy_o[g]`=1, operands, id and opcode of g are latched, `owner_q`←g, next state ISSUE.
  - Otherwise `req_rdy_o` is all zero.
- **ISSUE:**
  - `div_in_vld_o`=1 for exactly this cycle; `div_*_o` are driven from the holding registers.
  - Next state BUSY.
- **BUSY:**
  - `rsp_vld_o[owner_q]`=`div_out_vld_i`, and all other bits are 0.
  - `rsp_res_o`=`div_res_i` and `rsp_id_o`=`div_id_i`.
  - `div_out_rdy_o`=`rsp_rdy_i[owner_q]`.
  - On `div_out_vld_i` & `rsp_rdy_i[owner_q]`: next state IDLE, `ptr_q`←(owner_q+1) mod NUM_REQ.
- **Flush:**
  - If `req_flush_i[owner_q]` is high in ISSUE or BUSY: `div_flush_o`=1 for that cycle, `div_in_vld_o`=0, `rsp_vld_o`=0, `div_out_rdy_o`=0.
  - After an owner flush: next state IDLE, `ptr_q`←(owner_q+1) mod NUM_REQ.
  - A flush of a non-owner has no effect on the divider.
  - A flushed requester in IDLE is not granted that cycle.
- **Simultaneous events:**
  - Owner flush in the same cycle as a result handshake: the flush wins and no response is delivered.
  - A request arriving while in ISSUE or BUSY waits; `req_rdy_o`=0.
- **Outputs outside the active state:**
  - `div_op_*_o`, `div_id_o` and `div_opcode_o` always reflect the holding registers.
  - `rsp_res_o`/`rsp_id_o` are only meaningful when a `rsp_vld_o` bit is high.

## Timing
- **Reset** (`rst_ni` low at a rising edge, any state, including mid-operation):
  - State←IDLE, `ptr_q`←0, `owner_q`←0, holding registers←0.
  - Every output is then 0: `req_rdy_o`, `rsp_vld_o`, `div_in_vld_o`, `div_flush_o`, `div_out_rdy_o`, `rsp_res_o`, `rsp_id_o`, `div_id_o`, `div_op_a_o`, `div_op_b_o` and `div_opcode_o`.
  - An in-flight result is dropped. The divider is reset by the same `rst_ni` and needs no flush.
- **Latency:**
  - Accept in cycle T, `div_in_vld_o` in T+1, divider starts in T+2.
  - The response path adds zero cycles; it is combinational from the divider outputs.
- **Back-to-back:**
  - After a result handshake in cycle T, IDLE holds at T+1.
  - A new accept is possible at T+1 if `div_in_rdy_i`=1.
- **Backpressure:**
  - While `rsp_rdy_i[owner_q]`=0, the divider holds its result and `rsp_vld_o[owner_q]` stays high.
  - `rsp_res_o` stays stable during backpressure.
- **Fairness:** with all NUM_REQ requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0.

## Test plan
- **Single request:** requester 0 with op_a=100, op_b=7, opcode=0, id=5 → `req_rdy_o`=01 for one cycle, `div_in_vld_o` exactly one cycle later, then `rsp_vld_o`=01 with `rsp_res_o`=14 and `rsp_id_o`=5. `rsp_vld_o[1]` never goes high.
- **Contention (NUM_REQ=2):** both requesters continuously valid → grant order 0,1,0,1; each accept occurs one cycle after the previous result handshake. Requester 1 runs rem of −7 by 2 and must get −1.
- **Owner flush in BUSY:** requester 1 issues, then `req_flush_i[1]` pulses mid-division → `div_flush_o` one cycle, no `rsp_vld_o`, state IDLE. The next grant goes to requester 0.
- **Non-owner flush:** flush requester 1 while requester 0 owns the divider → `div_flush_o` stays 0 and requester 0 receives its correct result.
- **Backpressure:** hold `rsp_rdy_i[0]`=0 for 5 cycles after `div_out_vld_i` → `rsp_vld_o[0]` high, `rsp_res_o` stable and `div_out_rdy_o`=0 throughout; release → a single handshake, then IDLE.
- **Reset mid-op:** drop `rst_ni` during BUSY → all outputs 0 on the next edge and `ptr_q`=0. After release, a request from requester 0 completes normally.
